// File: rtl/fifo_sc_ctrl_if.sv
// Producer/consumer handshake bundle for the single-clock FIFO controller.
// master: the side that pushes words and takes them back out.
// slave:  the FIFO controller itself.
interface fifo_sc_ctrl_if #(
   parameter int unsigned data_width = 8
);

   logic                  in_valid;
   logic                  in_ready;
   logic [data_width-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [data_width-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/fifo_sc_ctrl.sv
// Show-ahead FIFO controller sequencing one dual-port RAM (registered read port).
// The head word is kept on ram_do by re-reading the head slot while the consumer stalls.
module fifo_sc_ctrl #(
   parameter int unsigned addr_width = 8,
   parameter int unsigned data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   fifo_sc_ctrl_if.slave         bus,
   output logic [addr_width:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  ram_we,
   output logic [addr_width-1:0] ram_waddr,
   output logic [data_width-1:0] ram_di,
   output logic [addr_width-1:0] ram_raddr,
   output logic                  ram_oe,
   input  logic [data_width-1:0] ram_do
);

   localparam logic [addr_width:0]   ptr_one  = (addr_width + 1)'(1);
   localparam logic [addr_width-1:0] addr_one = addr_width'(1);

   logic [addr_width:0] wptr_q, wptr_d;
   logic [addr_width:0] rptr_q, rptr_d;
   logic [addr_width:0] count_q, count_d;
   logic [addr_width:0] unread;
   logic                out_valid_q, out_valid_d;
   logic                in_rdy;
   logic                push, pop, rd_issue, hold;

   // Handshake decode and RAM port control.
   always_comb begin
      // count never exceeds the depth, so its MSB alone marks full.
      full      = count_q[addr_width];
      empty     = (count_q == '0);
      in_rdy    = !full && !rst;
      push      = bus.in_valid && in_rdy;
      pop       = out_valid_q && bus.out_ready;
      unread    = wptr_q - rptr_q;
      rd_issue  = !rst && (unread != '0) && (!out_valid_q || bus.out_ready);
      hold      = !rst && out_valid_q && !bus.out_ready;

      ram_we    = push;
      ram_waddr = wptr_q[addr_width-1:0];
      ram_di    = bus.in_data;
      ram_oe    = rd_issue || hold;
      // Holding re-reads the slot fetched last, i.e. one behind rptr.
      ram_raddr = rd_issue ? rptr_q[addr_width-1:0] : rptr_q[addr_width-1:0] - addr_one;

      bus.in_ready  = in_rdy;
      bus.out_valid = out_valid_q;
      bus.out_data  = ram_do;
      count         = count_q;
   end

   // Next-state for pointers, occupancy and the output-valid flag.
   always_comb begin
      wptr_d      = push ? wptr_q + ptr_one : wptr_q;
      rptr_d      = rd_issue ? rptr_q + ptr_one : rptr_q;
      out_valid_d = out_valid_q;
      if (rd_issue) begin
         out_valid_d = 1'b1;
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + ptr_one;
         2'b01:   count_d = count_q - ptr_one;
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset; RAM contents are left alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_fifo_sc_ctrl.sv
// Self-checking bench for fifo_sc_ctrl with a behavioural registered-read RAM.
module tb_fifo_sc_ctrl;

   localparam int unsigned aw = 8;
   localparam int unsigned dw = 8;

   logic          clk;
   logic          rst;
   logic [aw:0]   count;
   logic          full, empty;
   logic          ram_we, ram_oe;
   logic [aw-1:0] ram_waddr, ram_raddr;
   logic [dw-1:0] ram_di, ram_dout;

   logic [dw-1:0] mem [256];
   logic [dw-1:0] sb [$];
   int            n_checks = 0;
   int            n_fail   = 0;

   fifo_sc_ctrl_if #(.data_width(dw)) bus ();

   fifo_sc_ctrl #(
      .addr_width (aw),
      .data_width (dw)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_di    (ram_di),
      .ram_raddr (ram_raddr),
      .ram_oe    (ram_oe),
      .ram_do    (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, registered read, output zero when not enabled.
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_di;
      ram_dout <= ram_oe ? mem[ram_raddr] : '0;
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every pop is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got %0h, expected no pop at %0t", bus.out_data, $time);
         end else begin
            chk("pop_data", 32'(bus.out_data), 32'(sb.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(string name, int budget);
      bus.out_ready = 1'b1;
      for (int k = 0; k < budget && sb.size() != 0; k++) tick();
      chk(name, sb.size(), 0);
      bus.out_ready = 1'b0;
      tick();
      @(negedge clk);
      chk({name, "_empty"}, 32'(empty), 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      // Reset with a producer already offering data.
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.out_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_we", 32'(ram_we), 0);
         chk("rst_in_ready", 32'(bus.in_ready), 0);
         tick();
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(bus.in_ready), 1);
      chk("post_rst_out_valid", 32'(bus.out_valid), 0);
      chk("post_rst_count", 32'(count), 0);
      chk("post_rst_empty", 32'(empty), 1);
      chk("post_rst_full", 32'(full), 0);
      tick();

      // Single word: two-cycle latency, popped on arrival.
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hA5;
      bus.out_ready = 1'b1;
      sb.push_back(8'hA5);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("single_t1_valid", 32'(bus.out_valid), 0);
      tick();
      @(negedge clk);
      chk("single_t2_valid", 32'(bus.out_valid), 1);
      chk("single_t2_data", 32'(bus.out_data), 32'hA5);
      tick();
      @(negedge clk);
      chk("single_t3_empty", 32'(empty), 1);
      chk("single_t3_valid", 32'(bus.out_valid), 0);
      bus.out_ready = 1'b0;
      tick();

      // Fill to depth with the consumer stalled.
      for (int i = 0; i < 256; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i);
         @(negedge clk);
         chk("fill_in_ready", 32'(bus.in_ready), 1);
         sb.push_back(8'(i));
         tick();
      end
      bus.in_data = 8'hEE;
      @(negedge clk);
      chk("full_flag", 32'(full), 1);
      chk("full_count", 32'(count), 256);
      chk("full_in_ready", 32'(bus.in_ready), 0);
      chk("full_no_we", 32'(ram_we), 0);
      chk("full_head", 32'(bus.out_data), 0);
      tick();
      // Pop at full with a push offered: the push must not be admitted.
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_count", 32'(count), 256);
      chk("full_pop_in_ready", 32'(bus.in_ready), 0);
      chk("full_pop_no_we", 32'(ram_we), 0);
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("after_full_pop_count", 32'(count), 255);
      chk("after_full_pop_in_ready", 32'(bus.in_ready), 1);
      drain("fill_drain", 300);

      // Backpressure: head word must stay put while the consumer stalls.
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h11 * (i + 1));
         sb.push_back(8'(8'h11 * (i + 1)));
         tick();
      end
      bus.in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 1);
         chk("bp_data", 32'(bus.out_data), 32'h11);
         chk("bp_oe", 32'(ram_oe), 1);
         tick();
      end
      drain("bp_drain", 20);

      // Streaming push/pop across pointer wrap.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 600; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i);
         sb.push_back(8'(i));
         @(negedge clk);
         chk("stream_in_ready", 32'(bus.in_ready), 1);
         if (i >= 2) chk("stream_count", 32'(count), 2);
         tick();
      end
      bus.in_valid = 1'b0;
      drain("stream_drain", 20);

      // Reset mid-operation discards contents.
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'h50 + i);
         tick();
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_count", 32'(count), 10);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      tick();
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h3C;
      sb.push_back(8'h3C);
      tick();
      bus.in_valid = 1'b0;
      drain("mid_rst_drain", 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
